mul_seq: RTL and testbench

- Iterative radix-2 shift-add multiply sequencer for the execute stage of the pipelined ARM core.
- Executes MUL, MLA, UMULL and SMULL over XLEN+2 cycles.
- Asserts a stall request so the hazard logic holds the instruction in Execute until the result is valid.
- The writeback mux takes ResultLo/ResultHi on the done cycle.

---
 rtl/mul_seq_if.sv | 26 ++
 rtl/mul_seq.sv | 131 +++++++++++++
 tb/tb_mul_seq.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/mul_seq_if.sv
// Execute-stage multiply bus: issue, operands and flush in; stall, status and result out.
interface mul_seq_if #(
  parameter int unsigned XLEN = 32
);
  logic            StartE;
  logic [1:0]      MulOpE;
  logic [XLEN-1:0] SrcAE;
  logic [XLEN-1:0] SrcBE;
  logic [XLEN-1:0] SrcCE;
  logic            FlushE;
  logic            StallMul;
  logic            Busy;
  logic            Done;
  logic [XLEN-1:0] ResultLo;
  logic [XLEN-1:0] ResultHi;

  modport master (
    output StartE, MulOpE, SrcAE, SrcBE, SrcCE, FlushE,
    input  StallMul, Busy, Done, ResultLo, ResultHi
  );

  modport slave (
    input  StartE, MulOpE, SrcAE, SrcBE, SrcCE, FlushE,
    output StallMul, Busy, Done, ResultLo, ResultHi
  );
endinterface

// File: rtl/mul_seq.sv
// Radix-2 shift-add multiply sequencer (MUL/MLA/UMULL/SMULL), XLEN+2 cycles from accept to Done.
// SMULL runs on magnitudes and fixes the sign in the FIN cycle.
module mul_seq #(
  parameter int unsigned XLEN = 32
) (
  input  logic      clk,
  input  logic      reset,
  mul_seq_if.slave  bus
);
  localparam int unsigned CntW = $clog2(XLEN) + 1;
  localparam int unsigned PW   = 2 * XLEN;

  typedef enum logic [1:0] {StIdle, StRun, StFin, StDone} state_e;

  state_e          r_state, w_state_next;
  logic [CntW-1:0] r_count;
  logic [PW-1:0]   r_acc;
  logic [PW-1:0]   r_mcand;
  logic [XLEN-1:0] r_mplier;
  logic [XLEN-1:0] r_srcc;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_hi;
  logic [1:0]      r_op;
  logic            r_neg;
  logic            r_done;

  logic            w_accept;
  logic            w_busy;
  logic            w_last;
  logic            w_signed;
  logic [XLEN-1:0] w_mag_a;
  logic [XLEN-1:0] w_mag_b;
  logic [PW-1:0]   w_prod;
  logic [XLEN-1:0] w_lo_next;
  logic [XLEN-1:0] w_hi_next;

  assign w_accept = (r_state == StIdle) && bus.StartE && !bus.FlushE;
  assign w_busy   = (r_state == StRun) || (r_state == StFin);
  assign w_last   = (r_count == CntW'(XLEN - 1));

  // 2^(XLEN-1) negates to itself, which is the correct unsigned magnitude.
  assign w_signed = (bus.MulOpE == 2'b11);
  assign w_mag_a  = (w_signed && bus.SrcAE[XLEN-1]) ? (~bus.SrcAE + XLEN'(1)) : bus.SrcAE;
  assign w_mag_b  = (w_signed && bus.SrcBE[XLEN-1]) ? (~bus.SrcBE + XLEN'(1)) : bus.SrcBE;

  always_comb begin
    w_prod    = r_acc;
    w_lo_next = '0;
    w_hi_next = '0;
    if (r_op == 2'b11 && r_neg) begin
      w_prod = ~r_acc + PW'(1);
    end
    unique case (r_op)
      2'b00: w_lo_next = w_prod[XLEN-1:0];
      2'b01: w_lo_next = w_prod[XLEN-1:0] + r_srcc;
      default: begin
        w_lo_next = w_prod[XLEN-1:0];
        w_hi_next = w_prod[PW-1:XLEN];
      end
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: if (w_accept) w_state_next = StRun;
      StRun: begin
        if (bus.FlushE)  w_state_next = StIdle;
        else if (w_last) w_state_next = StFin;
      end
      StFin:  w_state_next = bus.FlushE ? StIdle : StDone;
      StDone: w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= StIdle;
      r_count  <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_srcc   <= '0;
      r_lo     <= '0;
      r_hi     <= '0;
      r_op     <= '0;
      r_neg    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_count  <= '0;
            r_acc    <= '0;
            r_mcand  <= {{XLEN{1'b0}}, w_mag_a};
            r_mplier <= w_mag_b;
            r_srcc   <= bus.SrcCE;
            r_op     <= bus.MulOpE;
            r_neg    <= w_signed && (bus.SrcAE[XLEN-1] ^ bus.SrcBE[XLEN-1]);
          end
        end
        StRun: begin
          if (!bus.FlushE) begin
            if (r_mplier[0]) r_acc <= r_acc + r_mcand;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count + CntW'(1);
          end
        end
        StFin: begin
          if (!bus.FlushE) begin
            r_lo   <= w_lo_next;
            r_hi   <= w_hi_next;
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Accept term is combinational so the pipeline holds in the accept cycle itself.
  assign bus.StallMul = (w_accept && !reset) || w_busy;
  assign bus.Busy     = w_busy;
  assign bus.Done     = r_done;
  assign bus.ResultLo = r_lo;
  assign bus.ResultHi = r_hi;
endmodule

// File: tb/tb_mul_seq.sv
// Bench for mul_seq: directed and random operations checked against a plain-arithmetic model.
module tb_mul_seq;
  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  logic [63:0] last_exp = '0;

  always #5 clk = ~clk;

  mul_seq_if #(.XLEN(32)) bus ();

  mul_seq #(.XLEN(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] c);
    longint sa;
    longint sb;
    logic [31:0] p32;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    p32 = a * b;
    case (op)
      2'b00:   return {32'h0, p32};
      2'b01:   return {32'h0, p32 + c};
      2'b10:   return {32'h0, a} * {32'h0, b};
      default: return 64'(sa * sb);
    endcase
  endfunction

  // Issues one operation from IDLE and checks the full timeline up to the Done cycle.
  task automatic do_op(input string name, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] c, input logic [63:0] exp,
                       input bit keep);
    chk({name, ":pre_done"}, 64'(bus.Done), 64'd0);
    bus.StartE = 1'b1;
    bus.FlushE = 1'b0;
    bus.MulOpE = op;
    bus.SrcAE  = a;
    bus.SrcBE  = b;
    bus.SrcCE  = c;
    #1;
    chk({name, ":accept_stall"}, 64'(bus.StallMul), 64'd1);
    chk({name, ":accept_busy"}, 64'(bus.Busy), 64'd0);
    for (int k = 1; k <= 33; k++) begin
      step();
      // Operands must have been latched; scramble the live inputs.
      bus.MulOpE = 2'($urandom_range(0, 3));
      bus.SrcAE  = $urandom;
      bus.SrcBE  = $urandom;
      bus.SrcCE  = $urandom;
      chk({name, ":run_busy"}, 64'(bus.Busy), 64'd1);
      chk({name, ":run_done"}, 64'(bus.Done), 64'd0);
      chk({name, ":run_stall"}, 64'(bus.StallMul), 64'd1);
    end
    step();
    chk({name, ":done"}, 64'(bus.Done), 64'd1);
    chk({name, ":done_busy"}, 64'(bus.Busy), 64'd0);
    chk({name, ":done_stall"}, 64'(bus.StallMul), 64'd0);
    chk({name, ":result"}, {bus.ResultHi, bus.ResultLo}, exp);
    last_exp = exp;
    if (!keep) bus.StartE = 1'b0;
  endtask

  initial begin
    int          seen;
    logic [1:0]  op;
    logic [31:0] a, b, c;

    reset      = 1'b1;
    bus.StartE = 1'b0;
    bus.FlushE = 1'b0;
    bus.MulOpE = 2'b00;
    bus.SrcAE  = '0;
    bus.SrcBE  = '0;
    bus.SrcCE  = '0;
    step();
    step();
    chk("rst_stall", 64'(bus.StallMul), 64'd0);
    chk("rst_busy", 64'(bus.Busy), 64'd0);
    chk("rst_done", 64'(bus.Done), 64'd0);
    chk("rst_lo", 64'(bus.ResultLo), 64'd0);
    chk("rst_hi", 64'(bus.ResultHi), 64'd0);
    reset = 1'b0;
    step();

    do_op("mul7x6", 2'b00, 32'd7, 32'd6, 32'd0, 64'h0000_0000_0000_002A, 1'b0);
    step();
    do_op("mla_wrap", 2'b01, 32'hFFFF_FFFF, 32'd2, 32'd5, 64'h0000_0000_0000_0003, 1'b0);
    step();
    do_op("umull_max", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 64'hFFFF_FFFE_0000_0001,
          1'b0);
    step();
    do_op("smull_m3x5", 2'b11, 32'hFFFF_FFFD, 32'd5, 32'd0, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0);
    step();
    do_op("smull_min", 2'b11, 32'h8000_0000, 32'h8000_0000, 32'd0, 64'h4000_0000_0000_0000,
          1'b0);
    step();

    // StartE held through DONE, second MUL issued from the following IDLE.
    a = $urandom;
    b = $urandom;
    do_op("b2b_first", 2'b00, a, b, 32'd0, model(2'b00, a, b, 32'd0), 1'b1);
    step();
    do_op("b2b_second", 2'b00, 32'd3, 32'd3, 32'd0, 64'd9, 1'b0);
    step();
    chk("b2b_single_done", 64'(bus.Done), 64'd0);

    for (int i = 0; i < 12; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      c  = $urandom;
      if (i == 0) a = 32'h8000_0000;
      if (i == 1) b = 32'hFFFF_FFFF;
      do_op("rand", op, a, b, c, model(op, a, b, c), 1'b0);
      step();
    end

    // Flush in IDLE blocks the accept.
    bus.StartE = 1'b1;
    bus.FlushE = 1'b1;
    #1;
    chk("idle_flush_stall", 64'(bus.StallMul), 64'd0);
    step();
    chk("idle_flush_busy", 64'(bus.Busy), 64'd0);
    bus.StartE = 1'b0;
    bus.FlushE = 1'b0;
    step();

    // Flush at RUN iteration 10.
    bus.StartE = 1'b1;
    bus.MulOpE = 2'b10;
    bus.SrcAE  = $urandom;
    bus.SrcBE  = $urandom;
    step();
    repeat (10) step();
    chk("flush_mid_busy", 64'(bus.Busy), 64'd1);
    bus.FlushE = 1'b1;
    bus.StartE = 1'b0;
    step();
    bus.FlushE = 1'b0;
    chk("flush_busy", 64'(bus.Busy), 64'd0);
    chk("flush_stall", 64'(bus.StallMul), 64'd0);
    chk("flush_result", {bus.ResultHi, bus.ResultLo}, last_exp);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus.Done) seen++;
      step();
    end
    chk("flush_no_done", 64'(seen), 64'd0);
    chk("flush_result_kept", {bus.ResultHi, bus.ResultLo}, last_exp);

    // Reset at RUN iteration 20.
    bus.StartE = 1'b1;
    bus.MulOpE = 2'b11;
    bus.SrcAE  = $urandom;
    bus.SrcBE  = $urandom;
    step();
    repeat (20) step();
    reset      = 1'b1;
    bus.StartE = 1'b0;
    step();
    chk("rrun_busy", 64'(bus.Busy), 64'd0);
    chk("rrun_stall", 64'(bus.StallMul), 64'd0);
    chk("rrun_done", 64'(bus.Done), 64'd0);
    chk("rrun_lo", 64'(bus.ResultLo), 64'd0);
    chk("rrun_hi", 64'(bus.ResultHi), 64'd0);
    reset = 1'b0;
    step();

    a = $urandom;
    b = $urandom;
    c = $urandom;
    do_op("after_reset", 2'b01, a, b, c, model(2'b01, a, b, c), 1'b0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
